// File: rtl/dev_pkg.sv
// Shared constants for the board-device blocks.
package dev_pkg;

  localparam int unsigned DIP_W               = 8;
  localparam int unsigned DEBOUNCE_10MS_12MHZ = 120000;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchronizer followed by a vector debouncer with a registered accept strobe.
module debounce
  import dev_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             invert,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             strobe
);

  localparam int unsigned    CW      = cnt_width(CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  // Polarity is applied after the synchronizer so the flops see the raw pin.
  assign sync = sync_q2 ^ {WIDTH{invert}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      stable  <= '0;
      cand    <= '0;
      cnt     <= '0;
      strobe  <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      strobe  <= 1'b0;
      if (sync == stable) begin
        cand <= sync;
        cnt  <= '0;
      end else if (sync != cand) begin
        cand <= sync;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= cand;
        cnt    <= '0;
        strobe <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_dip_switch.sv
// DIP-switch and push-button front end: debounced levels, change/press strobes, press snapshot.
module dev_dip_switch
  import dev_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIP_W-1:0] dip_pins,
  input  logic             btn_pin,
  output logic [DIP_W-1:0] dip_val,
  output logic             dip_changed,
  output logic             btn_level,
  output logic             btn_press,
  output logic [DIP_W-1:0] latched_val
);

  logic [DIP_W-1:0] dip_prev;
  logic             btn_strobe;

  debounce #(
    .WIDTH  (DIP_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_dip (
    .clk    (clk),
    .rst    (rst),
    .invert (ACTIVE_LOW),
    .din    (dip_pins),
    .stable (dip_val),
    .strobe (dip_changed)
  );

  debounce #(
    .WIDTH  (1),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .invert (ACTIVE_LOW),
    .din    (btn_pin),
    .stable (btn_level),
    .strobe (btn_strobe)
  );

  // Both terms are registered; a strobe with the level now high is a rising edge.
  assign btn_press = btn_strobe & btn_level;

  // dip_prev holds the switch value from before the press edge, so a switch
  // update landing on the same edge as the button is not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_prev    <= '0;
      latched_val <= '0;
    end else begin
      dip_prev <= dip_val;
      if (btn_press) begin
        latched_val <= dip_prev;
      end
    end
  end

endmodule

// File: doc/dev_dip_switch.md
# dev_dip_switch

Input-side counterpart to `dev_hex`: reads the 8 DIP-switch pins and one push-button pin, synchronizes and debounces them, and presents clean registered values to the core. Beyond the stable levels it emits single-cycle change and press strobes, plus a snapshot of the switch value taken on each button press. Top-level designs instantiate it between the raw board pins and any logic that consumes switch settings, for example a `dev_hex` display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 120000 (10 ms at 12 MHz): consecutive stable cycles required before a change is accepted. Must be ≥ 1.
- `ACTIVE_LOW`, default 0: when 1, every pin is inverted after synchronization, so `dip_val`/`btn_level` read 1 for a pulled-low pin.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset; asynchronous and active-high.
- `dip_pins`  in  8  raw switch pins, asynchronous to `clk`; bit i maps to `dip_val[i]`.
- `btn_pin`  in  1  raw button pin, asynchronous.
- `dip_val`  out  8  debounced switch value.
- `dip_changed`  out  1  one-cycle strobe, high in the first cycle a new `dip_val` is visible.
- `btn_level`  out  1  debounced button level.
- `btn_press`  out  1  one-cycle strobe on an accepted 0→1 transition of `btn_level`.
- `latched_val`  out  8  `dip_val` captured on each `btn_press`.

## Operation

- Every pin passes through a 2-flop synchronizer, then the optional inversion. The result is called `sync`.
- Each debounce group (8-bit switches; 1-bit button) holds three registers: `stable` (the output), `cand` (the candidate value) and `cnt` (width `$clog2(DEBOUNCE_CYCLES)`, minimum 1).
- Per-edge rules, in priority order:
  1. `sync == stable`: set `cand <= sync`, `cnt <= 0`.
  2. `sync != cand`: set `cand <= sync`, `cnt <= 0`. Any bounce restarts the count.
  3. `sync == cand`, `cnt == DEBOUNCE_CYCLES-1`: set `stable <= cand`, `cnt <= 0`, and strobe.
  4. Otherwise: `cnt <= cnt + 1`.
- The switch group is debounced as one vector: any bit moving during the count restarts it, and a multi-bit change is accepted atomically.
- `dip_changed` and `btn_press` are registered, so each is high exactly in the cycle its new `stable` value is first visible.
- `btn_press` fires only on 0→1. A 1→0 transition updates `btn_level` with no strobe.
- On `btn_press`, `latched_val` takes the `dip_val` visible in the previous cycle. If the switch and button updates land on the same edge, the pre-update switch value is latched.

## Timing

- **Latency:** a pin change held steady from before edge 1 is synchronized at edge 2, loaded into `cand` at edge 3, and visible on the output at edge `DEBOUNCE_CYCLES+3`. With `DEBOUNCE_CYCLES=4` that is 7 cycles.
- **Strobes:** one-cycle pulses, never back-to-back. At least `DEBOUNCE_CYCLES+1` cycles separate two strobes of the same group.
- **Reset:**
  - All synchronizer flops, `stable`, `cand`, `cnt`, `dip_val`, `btn_level`, `latched_val`, `dip_changed` and `btn_press` are 0.
  - Reset assertion clears them immediately, including mid-count; no strobe is emitted.
  - If pins are nonzero after reset, the normal change path applies. The first `dip_changed`/`btn_press` appears at edge `DEBOUNCE_CYCLES+3` after reset release.
- **Counter wrap:** impossible, because `cnt` never exceeds `DEBOUNCE_CYCLES-1`.

## Structure

- Package `dev_pkg` holds `DIP_W = 8` and the `DEBOUNCE_10MS_12MHZ = 120000` constant.
- The synchronizer and debounce logic lives in one sub-module, `debounce`, with parameters `WIDTH` and `CYCLES`, outputs `stable`/`strobe`, and clock/reset named `clk`/`rst`.
- `dev_dip_switch` instantiates `debounce` twice (`WIDTH=8`, `WIDTH=1`) and adds the inversion, rising-edge qualification and `latched_val` register.

## Test plan

All scenarios run with `DEBOUNCE_CYCLES=4`, `ACTIVE_LOW=0`.
- **Clean change:** `dip_pins` 0x00→0xA5 held → `dip_val`=0xA5 and `dip_changed`=1 for one cycle, at edge 7 after the change; no other strobe.
- **Bounce:** `dip_pins`=0x01 for 3 cycles, 0x00 for 1, then 0x01 held → the count restarts; `dip_val`=0x01 exactly 7 edges after the final transition, with a single `dip_changed`.
- **Button press:** `dip_pins`=0x3C stable, then `btn_pin` 0→1 held → `btn_press` pulses once at edge 7 and `latched_val`=0x3C. Release then `btn_pin` 1→0 → `btn_level`=0 with no `btn_press`.
- **Simultaneous updates:** `dip_pins` 0x3C→0xFF and `btn_pin` 0→1 on the same edge → both strobes in the same cycle; `latched_val`=0x3C, `dip_val`=0xFF.
- **Reset mid-count:** `dip_pins`=0x80 then `rst` pulsed at edge 5 → all outputs 0 immediately, no strobe. After release, `dip_val`=0x80 and `dip_changed` at edge 7.
- **Inversion:** `ACTIVE_LOW=1`, pins held 0xFF through reset → `dip_val` stays 0x00 and no `dip_changed` ever fires.
